// File: rtl/wgt_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
//   Shared definitions for the CNN weight path: default widths, the weight
//   group size (equal to the downstream shift-buffer depth) and the state
//   encoding of the weight fetch controller.
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int WGT_W_DEF   = 8;
  localparam int NUM_WGT_DEF = 4;
  localparam int GRP_W_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_HOLD,
    ST_DONE
  } wgt_fetch_state_e;

endpackage

// File: rtl/wgt_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// wgt_fetch_ctrl_if
//   Bundles the weight SRAM read port, the shift-buffer feed and the group
//   handshake of the weight fetch controller.
//   master : the fetch controller (drives reads, weights, grp_valid)
//   slave  : SRAM + shift buffer + PE side (drives mem_rdata, grp_ack)
//   Signals: mem_rd_en, mem_addr, mem_rdata, wgt_out, wgt_read,
//            grp_valid, grp_ack
// -----------------------------------------------------------------------------
interface wgt_fetch_ctrl_if import cnn_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WGT_W  = WGT_W_DEF
) ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WGT_W-1:0]  mem_rdata;
  logic [WGT_W-1:0]  wgt_out;
  logic              wgt_read;
  logic              grp_valid;
  logic              grp_ack;

  modport master (
    output mem_rd_en, mem_addr, wgt_out, wgt_read, grp_valid,
    input  mem_rdata, grp_ack
  );

  modport slave (
    input  mem_rd_en, mem_addr, wgt_out, wgt_read, grp_valid,
    output mem_rdata, grp_ack
  );

endinterface

// File: rtl/wgt_fetch_ctrl_rd_lat_pipe.sv
// -----------------------------------------------------------------------------
// rd_lat_pipe
//   RD_LAT-deep shift register that tracks which SRAM cycles carry valid read
//   data. A synchronous flush drops every read still in flight.
//   clk, rst_n : clock, async active-low reset
//   flush      : clear all stages on the next edge
//   in_valid   : a read is issued this cycle
//   out_valid  : read data issued RD_LAT cycles ago is on the SRAM bus now
// -----------------------------------------------------------------------------
module rd_lat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic out_valid
);

  logic [RD_LAT-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else if (flush) begin
      stage <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        stage[i] <= stage[i-1];
      end
      stage[0] <= in_valid;
    end
  end

  assign out_valid = stage[RD_LAT-1];

endmodule

// File: rtl/wgt_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// wgt_fetch_ctrl
//   Reads weight groups (NUM_WGT consecutive words each) from the weight SRAM
//   and shifts them serially into the downstream shift buffer. A loaded group
//   is held with grp_valid until the PE side acknowledges it.
//   clk, rst_n : clock, async active-low reset
//   start      : 1-cycle start pulse, honoured only in IDLE
//   base_addr  : first SRAM word address, sampled with start
//   num_grp    : number of groups, sampled with start (0 = finish at once)
//   clr        : synchronous abort back to IDLE
//   busy       : controller not idle
//   done       : 1-cycle pulse after the last group is acknowledged
//   bus        : SRAM read port, shift-buffer feed and group handshake
// -----------------------------------------------------------------------------
module wgt_fetch_ctrl import cnn_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int WGT_W   = WGT_W_DEF,
  parameter int NUM_WGT = NUM_WGT_DEF,
  parameter int GRP_W   = GRP_W_DEF,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [GRP_W-1:0]  num_grp,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  wgt_fetch_ctrl_if.master  bus
);

  localparam int CNT_W = $clog2(NUM_WGT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WGT - 1);

  wgt_fetch_state_e  state_q, state_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [GRP_W-1:0]  grp_left;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_en;
  logic              pipe_out;
  logic              wgt_read_q;
  logic [WGT_W-1:0]  wgt_q;
  logic              done_q;

  assign rd_en = (state_q == ST_FETCH);

  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clr),
    .in_valid  (rd_en),
    .out_valid (pipe_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN ends on the last shift of the group so that grp_valid rises the
  // cycle after it; the last shift always lands in DRAIN because data
  // returns at least two cycles after the last issue.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (num_grp != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (issue_cnt == LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wgt_read_q && (rd_cnt == LAST)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.grp_ack) begin
          state_d = (grp_left == GRP_W'(1)) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address keeps running across groups; the word counters wrap to zero at
  // the end of every group so the next group needs no explicit reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      grp_left  <= '0;
      issue_cnt <= '0;
      rd_cnt    <= '0;
    end else if (clr) begin
      cur_addr  <= '0;
      grp_left  <= '0;
      issue_cnt <= '0;
      rd_cnt    <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        cur_addr <= base_addr;
        grp_left <= num_grp;
      end
      if (rd_en) begin
        cur_addr  <= cur_addr + 1'b1;
        issue_cnt <= (issue_cnt == LAST) ? '0 : issue_cnt + 1'b1;
      end
      if (wgt_read_q) begin
        rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
      end
      if ((state_q == ST_HOLD) && bus.grp_ack) begin
        grp_left <= grp_left - 1'b1;
      end
    end
  end

  // Registered shift-buffer feed and done pulse; clr suppresses both so that
  // aborted reads never reach the buffer and no done is signalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wgt_read_q <= 1'b0;
      wgt_q      <= '0;
      done_q     <= 1'b0;
    end else if (clr) begin
      wgt_read_q <= 1'b0;
      wgt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      wgt_read_q <= pipe_out;
      if (pipe_out) wgt_q <= bus.mem_rdata;
      done_q <= (state_q == ST_DONE);
    end
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_en ? cur_addr : '0;
  assign bus.wgt_out   = wgt_q;
  assign bus.wgt_read  = wgt_read_q;
  assign bus.grp_valid = (state_q == ST_HOLD);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_wgt_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wgt_fetch_ctrl
//   Drives two controllers (RD_LAT=1 and RD_LAT=3) against SRAM models where
//   word a holds (a - 0x00F). Expected addresses and weights are queued when a
//   start is issued and consumed as the controllers read and shift.
// -----------------------------------------------------------------------------
module tb_wgt_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller A: RD_LAT = 1
  logic       start_a = 1'b0, clr_a = 1'b0, busy_a, done_a;
  logic [9:0] base_a = '0;
  logic [7:0] ngrp_a = '0;
  wgt_fetch_ctrl_if #(.ADDR_W(10), .WGT_W(8)) bus_a ();

  wgt_fetch_ctrl #(.ADDR_W(10), .WGT_W(8), .NUM_WGT(4), .GRP_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_a),
    .num_grp(ngrp_a), .clr(clr_a), .busy(busy_a), .done(done_a), .bus(bus_a.master)
  );

  // Controller B: RD_LAT = 3
  logic       start_b = 1'b0, clr_b = 1'b0, busy_b, done_b;
  logic [9:0] base_b = '0;
  logic [7:0] ngrp_b = '0;
  wgt_fetch_ctrl_if #(.ADDR_W(10), .WGT_W(8)) bus_b ();

  wgt_fetch_ctrl #(.ADDR_W(10), .WGT_W(8), .NUM_WGT(4), .GRP_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b),
    .num_grp(ngrp_b), .clr(clr_b), .busy(busy_b), .done(done_b), .bus(bus_b.master)
  );

  function automatic logic [7:0] mem_val(input logic [9:0] a);
    logic [9:0] t;
    t = a - 10'h00F;
    return t[7:0];
  endfunction

  // SRAM models with read latency 1 and 3
  logic [7:0] sb0, sb1, sb2;
  initial begin
    bus_a.grp_ack = 1'b0;
    bus_b.grp_ack = 1'b0;
  end
  always @(posedge clk) begin
    if (bus_a.mem_rd_en) bus_a.mem_rdata <= mem_val(bus_a.mem_addr);
    sb0 <= bus_b.mem_rd_en ? mem_val(bus_b.mem_addr) : 8'h00;
    sb1 <= sb0;
    sb2 <= sb1;
  end
  assign bus_b.mem_rdata = sb2;

  // Scoreboards and shift-buffer models
  logic [9:0]  exp_addr_a[$], exp_addr_b[$];
  logic [7:0]  exp_data_a[$], exp_data_b[$];
  int          rd_cyc_a[$], rd_cyc_b[$];
  int          rd_total_a = 0, wr_total_a = 0, done_cnt_a = 0, last_wr_a = -10;
  int          rd_total_b = 0, wr_total_b = 0, done_cnt_b = 0, last_wr_b = -10;
  logic [31:0] buf_a = '0, buf_b = '0;
  logic        gv_prev_a = 1'b0, gv_prev_b = 1'b0;
  logic [9:0]  ea_a, ea_b;
  logic [7:0]  ed_a, ed_b;
  int          c_a, c_b;

  always @(negedge clk) if (rst_n) begin
    if (bus_a.mem_rd_en) begin
      rd_total_a++;
      rd_cyc_a.push_back(cyc);
      checks++;
      if (exp_addr_a.size() == 0) begin
        errors++;
        $display("[TB] FAIL rd_addr_a: unexpected read at addr=%h, none required", bus_a.mem_addr);
      end else begin
        ea_a = exp_addr_a.pop_front();
        if (bus_a.mem_addr !== ea_a) begin
          errors++;
          $display("[TB] FAIL rd_addr_a: got %h, want %h", bus_a.mem_addr, ea_a);
        end
      end
    end
    if (bus_a.wgt_read) begin
      wr_total_a++;
      last_wr_a = cyc;
      buf_a = {buf_a[23:0], bus_a.wgt_out};
      checks++;
      if (exp_data_a.size() == 0) begin
        errors++;
        $display("[TB] FAIL wgt_a: unexpected wgt_read with %h, none required", bus_a.wgt_out);
      end else begin
        ed_a = exp_data_a.pop_front();
        if (bus_a.wgt_out !== ed_a) begin
          errors++;
          $display("[TB] FAIL wgt_a: got %h, want %h", bus_a.wgt_out, ed_a);
        end
      end
      checks++;
      if (rd_cyc_a.size() == 0) begin
        errors++;
        $display("[TB] FAIL lat_a: wgt_read with no read issued, want a prior read");
      end else begin
        c_a = rd_cyc_a.pop_front();
        if (cyc - c_a != 2) begin
          errors++;
          $display("[TB] FAIL lat_a: latency %0d, want 2", cyc - c_a);
        end
      end
      checks++;
      if (bus_a.grp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL overlap_a: grp_valid=%b during wgt_read, want 0", bus_a.grp_valid);
      end
    end
    if (bus_a.grp_valid && !gv_prev_a) begin
      checks++;
      if (cyc != last_wr_a + 1) begin
        errors++;
        $display("[TB] FAIL gv_rise_a: rose at %0d, want %0d", cyc, last_wr_a + 1);
      end
    end
    gv_prev_a = bus_a.grp_valid;
    if (done_a) done_cnt_a++;
  end

  always @(negedge clk) if (rst_n) begin
    if (bus_b.mem_rd_en) begin
      rd_total_b++;
      rd_cyc_b.push_back(cyc);
      checks++;
      if (exp_addr_b.size() == 0) begin
        errors++;
        $display("[TB] FAIL rd_addr_b: unexpected read at addr=%h, none required", bus_b.mem_addr);
      end else begin
        ea_b = exp_addr_b.pop_front();
        if (bus_b.mem_addr !== ea_b) begin
          errors++;
          $display("[TB] FAIL rd_addr_b: got %h, want %h", bus_b.mem_addr, ea_b);
        end
      end
    end
    if (bus_b.wgt_read) begin
      wr_total_b++;
      last_wr_b = cyc;
      buf_b = {buf_b[23:0], bus_b.wgt_out};
      checks++;
      if (exp_data_b.size() == 0) begin
        errors++;
        $display("[TB] FAIL wgt_b: unexpected wgt_read with %h, none required", bus_b.wgt_out);
      end else begin
        ed_b = exp_data_b.pop_front();
        if (bus_b.wgt_out !== ed_b) begin
          errors++;
          $display("[TB] FAIL wgt_b: got %h, want %h", bus_b.wgt_out, ed_b);
        end
      end
      checks++;
      if (rd_cyc_b.size() == 0) begin
        errors++;
        $display("[TB] FAIL lat_b: wgt_read with no read issued, want a prior read");
      end else begin
        c_b = rd_cyc_b.pop_front();
        if (cyc - c_b != 4) begin
          errors++;
          $display("[TB] FAIL lat_b: latency %0d, want 4", cyc - c_b);
        end
      end
    end
    if (bus_b.grp_valid && !gv_prev_b) begin
      checks++;
      if (cyc != last_wr_b + 1) begin
        errors++;
        $display("[TB] FAIL gv_rise_b: rose at %0d, want %0d", cyc, last_wr_b + 1);
      end
    end
    gv_prev_b = bus_b.grp_valid;
    if (done_b) done_cnt_b++;
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus_a.grp_valid;
      1:       return done_a;
      2:       return bus_b.grp_valid;
      default: return done_b;
    endcase
  endfunction

  // Bounded wait for a DUT flag; a timeout is recorded as a failed check.
  task automatic wait_for(input int sel, input string name, output int seen);
    seen = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (sig(sel)) begin
        seen = cyc;
        break;
      end
    end
    checks++;
    if (seen < 0) begin
      errors++;
      $display("[TB] FAIL %s: no assertion within 100 cycles, want one", name);
    end
  endtask

  task automatic push_group_a(input logic [9:0] base);
    logic [9:0] a;
    for (int i = 0; i < 4; i++) begin
      a = base + 10'(i);
      exp_addr_a.push_back(a);
      exp_data_a.push_back(mem_val(a));
    end
  endtask

  task automatic start_a_cmd(input logic [9:0] base, input logic [7:0] n, output int sc);
    @(posedge clk); #1;
    start_a = 1'b1; base_a = base; ngrp_a = n; sc = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic ack_a(output int ac);
    @(posedge clk); #1;
    bus_a.grp_ack = 1'b1; ac = cyc;
    @(posedge clk); #1;
    bus_a.grp_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, bus_a.mem_rd_en, bus_a.wgt_read, bus_a.grp_valid} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags_a: got %b, want 00000",
               {busy_a, done_a, bus_a.mem_rd_en, bus_a.wgt_read, bus_a.grp_valid});
    end
    checks++;
    if ({bus_a.mem_addr, bus_a.wgt_out} !== 18'h0) begin
      errors++;
      $display("[TB] FAIL reset_data_a: got %h, want 0", {bus_a.mem_addr, bus_a.wgt_out});
    end
    checks++;
    if ({busy_b, done_b, bus_b.mem_rd_en, bus_b.wgt_read, bus_b.grp_valid} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags_b: got %b, want 00000",
               {busy_b, done_b, bus_b.mem_rd_en, bus_b.wgt_read, bus_b.grp_valid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_group(input string tag);
    int sc, seen, ac, d0;
    d0 = done_cnt_a;
    buf_a = '0;
    push_group_a(10'h010);
    start_a_cmd(10'h010, 8'd1, sc);
    wait_for(0, {tag, "_gv"}, seen);
    checks++;
    if (buf_a !== 32'h01020304) begin
      errors++;
      $display("[TB] FAIL %s_buf: got %h, want 01020304", tag, buf_a);
    end
    checks++;
    if (exp_addr_a.size() + exp_data_a.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_left: %0d items pending, want 0", tag, exp_addr_a.size() + exp_data_a.size());
    end
    ack_a(ac);
    wait_for(1, {tag, "_done"}, seen);
    checks++;
    if (seen != ac + 2) begin
      errors++;
      $display("[TB] FAIL %s_done_time: at %0d, want %0d", tag, seen, ac + 2);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle: busy=%b, want 0", tag, busy_a);
    end
    @(negedge clk); #1;
    checks++;
    if (done_a !== 1'b0 || done_cnt_a != d0 + 1) begin
      errors++;
      $display("[TB] FAIL %s_done_pulse: done=%b count=%0d, want 0 and %0d", tag, done_a, done_cnt_a - d0, 1);
    end
  endtask

  task automatic test_two_groups;
    int sc, seen, ac, r0, w0, d0;
    d0 = done_cnt_a;
    buf_a = '0;
    push_group_a(10'h010);
    push_group_a(10'h014);
    start_a_cmd(10'h010, 8'd2, sc);
    wait_for(0, "two_gv1", seen);
    checks++;
    if (buf_a !== 32'h01020304) begin
      errors++;
      $display("[TB] FAIL two_buf1: got %h, want 01020304", buf_a);
    end
    r0 = rd_total_a;
    w0 = wr_total_a;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus_a.grp_valid !== 1'b1 || rd_total_a != r0 || wr_total_a != w0) begin
        errors++;
        $display("[TB] FAIL two_hold: gv=%b reads=%0d shifts=%0d, want 1 0 0",
                 bus_a.grp_valid, rd_total_a - r0, wr_total_a - w0);
      end
    end
    ack_a(ac);
    wait_for(0, "two_gv2", seen);
    checks++;
    if (buf_a !== 32'h05060708) begin
      errors++;
      $display("[TB] FAIL two_buf2: got %h, want 05060708", buf_a);
    end
    ack_a(ac);
    wait_for(1, "two_done", seen);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done_cnt_a != d0 + 1) begin
      errors++;
      $display("[TB] FAIL two_done_count: got %0d, want 1", done_cnt_a - d0);
    end
  endtask

  task automatic test_wrap;
    int sc, seen, ac;
    buf_a = '0;
    push_group_a(10'h3FE);
    start_a_cmd(10'h3FE, 8'd1, sc);
    wait_for(0, "wrap_gv", seen);
    checks++;
    if (buf_a !== 32'hEFF0F1F2) begin
      errors++;
      $display("[TB] FAIL wrap_buf: got %h, want eff0f1f2", buf_a);
    end
    ack_a(ac);
    wait_for(1, "wrap_done", seen);
  endtask

  task automatic test_zero_groups;
    int sc, seen, r0, w0;
    r0 = rd_total_a;
    w0 = wr_total_a;
    start_a_cmd(10'h100, 8'd0, sc);
    wait_for(1, "zero_done", seen);
    checks++;
    if (seen != sc + 2) begin
      errors++;
      $display("[TB] FAIL zero_done_time: at %0d, want %0d", seen, sc + 2);
    end
    checks++;
    if (rd_total_a != r0 || wr_total_a != w0) begin
      errors++;
      $display("[TB] FAIL zero_traffic: reads=%0d shifts=%0d, want 0 0", rd_total_a - r0, wr_total_a - w0);
    end
  endtask

  task automatic test_clr;
    int sc, w0, d0, gv;
    bit got;
    w0 = wr_total_a;
    d0 = done_cnt_a;
    got = 1'b0;
    push_group_a(10'h010);
    start_a_cmd(10'h010, 8'd1, sc);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (wr_total_a == w0 + 1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL clr_first_shift: no wgt_read within 50 cycles, want one");
    end
    @(posedge clk); #1;
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({busy_a, bus_a.grp_valid, bus_a.wgt_read, bus_a.mem_rd_en} !== 4'b0 || wr_total_a != w0 + 2) begin
      errors++;
      $display("[TB] FAIL clr_abort: flags=%b shifts=%0d, want 0000 and 2",
               {busy_a, bus_a.grp_valid, bus_a.wgt_read, bus_a.mem_rd_en}, wr_total_a - w0);
    end
    checks++;
    if (exp_addr_a.size() != 0) begin
      errors++;
      $display("[TB] FAIL clr_reads: %0d reads missing, want 0", exp_addr_a.size());
    end
    exp_data_a.delete();
    rd_cyc_a.delete();
    gv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (bus_a.grp_valid) gv++;
    end
    checks++;
    if (wr_total_a != w0 + 2 || gv != 0 || done_cnt_a != d0) begin
      errors++;
      $display("[TB] FAIL clr_quiet: shifts=%0d gv=%0d done=%0d, want 2 0 0", wr_total_a - w0, gv, done_cnt_a - d0);
    end
    test_single_group("after_clr");
  endtask

  task automatic test_spurious_lat3;
    int seen, ac;
    buf_b = '0;
    for (int i = 0; i < 4; i++) begin
      exp_addr_b.push_back(10'h010 + 10'(i));
      exp_data_b.push_back(8'(i + 1));
    end
    @(posedge clk); #1;
    start_b = 1'b1; base_b = 10'h010; ngrp_b = 8'd1;
    @(posedge clk); #1;
    start_b = 1'b0;
    @(posedge clk); #1;
    start_b = 1'b1; base_b = 10'h200; ngrp_b = 8'd5; bus_b.grp_ack = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0; bus_b.grp_ack = 1'b0;
    wait_for(2, "lat3_gv", seen);
    checks++;
    if (buf_b !== 32'h01020304) begin
      errors++;
      $display("[TB] FAIL lat3_buf: got %h, want 01020304", buf_b);
    end
    @(posedge clk); #1;
    bus_b.grp_ack = 1'b1; ac = cyc;
    @(posedge clk); #1;
    bus_b.grp_ack = 1'b0;
    wait_for(3, "lat3_done", seen);
    checks++;
    if (seen != ac + 2) begin
      errors++;
      $display("[TB] FAIL lat3_done_time: at %0d, want %0d", seen, ac + 2);
    end
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (done_cnt_b != 1 || rd_total_b != 4 || busy_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lat3_final: done=%0d reads=%0d busy=%b, want 1 4 0", done_cnt_b, rd_total_b, busy_b);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200us, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_group("single");
    test_two_groups();
    test_wrap();
    test_zero_groups();
    test_clr();
    test_spurious_lat3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
